// File: rtl/sync_updown_modcount_pkg.sv
// Shared constants and helpers for the synchronous counter library.
// Direction/mode encodings plus the prescaler width function.
package sync_count_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // A PRESCALE of 1 still needs a 1-bit register to stay legal.
    function automatic int psc_width(input int p);
        int w;
        w = $clog2(p);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_updown_modcount_if.sv
// Control and status bundle of the up/down modulus counter.
// The master side drives controls; the slave side is the counter.
interface sync_updown_modcount_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sat_mode;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             udf;

    modport master (
        output en,
        output up_down,
        output load,
        output load_val,
        output sat_mode,
        output clr_flags,
        input  count,
        input  tc,
        input  ovf,
        input  udf
    );

    modport slave (
        input  en,
        input  up_down,
        input  load,
        input  load_val,
        input  sat_mode,
        input  clr_flags,
        output count,
        output tc,
        output ovf,
        output udf
    );

endinterface

// File: rtl/sync_updown_modcount_prescaler.sv
// Clock-enable prescaler: one tick per PRESCALE enabled cycles.
// The tick is combinational so the count register steps on the same edge.
module sync_prescaler
    import sync_count_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = psc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/sync_updown_modcount.sv
// Up/down counter with programmable modulus, load, wrap/saturate
// modes, prescaled enable and sticky overflow/underflow flags.
module sync_updown_modcount
    import sync_count_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int PRESCALE  = 1,
    parameter int RESET_VAL = 0
) (
    input logic                  clk,
    input logic                  reset,
    sync_updown_modcount_if.slave bus
);

    if (WIDTH < 1) begin : g_bad_width
        $error("WIDTH must be at least 1");
    end
    if (MODULUS < 2 ||
        (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_bad_mod
        $error("MODULUS must be in 2..2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_psc
        $error("PRESCALE must be at least 1");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
        $error("RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH:0] MAX = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] TOP = MAX[WIDTH-1:0];

    // Anything above MODULUS-1 collapses onto it.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH:0] v);
        return (v > MAX) ? TOP : v[WIDTH-1:0];
    endfunction

    logic           tick;
    logic [WIDTH:0] cur;
    logic [WIDTH:0] nxt;
    logic           at_top;
    logic           at_bot;
    logic           dir_up;
    logic           up_evt;
    logic           dn_evt;
    logic           up_inc;
    logic           dn_dec;

    sync_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_psc (
        .clk  (clk),
        .reset(reset),
        .en   (bus.en),
        .clr  (bus.load),
        .tick (tick)
    );

    always_comb begin
        cur    = {1'b0, bus.count};
        at_top = (cur == MAX);
        at_bot = (cur == '0);
        dir_up = (bus.up_down == DIR_UP);
        up_evt = tick && dir_up && at_top;
        dn_evt = tick && !dir_up && at_bot;
        up_inc = tick && dir_up && !at_top;
        dn_dec = tick && !dir_up && !at_bot;
        nxt    = cur;
        unique case (1'b1)
            up_evt:  nxt = (bus.sat_mode == MODE_SAT) ? cur : '0;
            dn_evt:  nxt = (bus.sat_mode == MODE_SAT) ? cur : MAX;
            up_inc:  nxt = cur + ONE;
            dn_dec:  nxt = cur - ONE;
            default: nxt = cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.count <= RST;
            bus.tc    <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.udf   <= 1'b0;
        end else if (bus.load) begin
            bus.count <= clamp({1'b0, bus.load_val});
            bus.tc    <= 1'b0;
            bus.ovf   <= bus.ovf && !bus.clr_flags;
            bus.udf   <= bus.udf && !bus.clr_flags;
        end else begin
            // A new boundary event outranks a simultaneous clear.
            bus.count <= clamp(nxt);
            bus.tc    <= up_evt || dn_evt;
            bus.ovf   <= up_evt || (bus.ovf && !bus.clr_flags);
            bus.udf   <= dn_evt || (bus.udf && !bus.clr_flags);
        end
    end

endmodule
